mem_io_responder: RTL and testbench

- Memory-side responder for the CPU's byte-wide memory bus; this is the far end of the CPU's `mem_addr`/`mem_dout`/`mem_din`/`mem_wr` interface.
- Provides 128 KB of byte RAM plus the I/O map at `addr[17:16]==2'b11`:
  - 0x30000: UART-style byte in / byte out.
  - 0x30004: cycle counter read / program-stop write.
- Buffers RX and TX bytes in FIFOs.
- Drives `cpu_rdy_o`, which the CPU uses as its `rdy_in` freeze signal.

---
 rtl/mem_io_responder_if.sv | 26 ++
 rtl/mem_io_responder.sv | 117 +++++++++++
 tb/tb_mem_io_responder.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_io_responder_if.sv
// CPU memory bus plus RX/TX byte streams seen by the memory-side responder.
// The master side is the CPU/environment and the slave side is mem_io_responder.
interface mem_io_responder_if;
  logic [31:0] cpu_addr_i;
  logic [7:0]  cpu_data_i;
  logic        cpu_wr_i;
  logic [7:0]  cpu_data_o;
  logic        cpu_rdy_o;
  logic        rx_valid_i;
  logic [7:0]  rx_data_i;
  logic        rx_ready_o;
  logic        tx_valid_o;
  logic [7:0]  tx_data_o;
  logic        tx_ready_i;
  logic        program_done_o;

  modport master (
    output cpu_addr_i, cpu_data_i, cpu_wr_i, rx_valid_i, rx_data_i, tx_ready_i,
    input  cpu_data_o, cpu_rdy_o, rx_ready_o, tx_valid_o, tx_data_o, program_done_o
  );

  modport slave (
    input  cpu_addr_i, cpu_data_i, cpu_wr_i, rx_valid_i, rx_data_i, tx_ready_i,
    output cpu_data_o, cpu_rdy_o, rx_ready_o, tx_valid_o, tx_data_o, program_done_o
  );
endinterface

// File: rtl/mem_io_responder.sv
// Memory-side responder: 128 KB byte RAM, UART-style byte I/O through RX/TX FIFOs,
// cycle counter with snapshot, and a sticky program-stop flag.
module mem_io_responder #(
  parameter int unsigned RAM_AW    = 17,
  parameter int unsigned FIFO_LOG2 = 3
) (
  input  logic              clk_in,
  input  logic              rst_in,
  mem_io_responder_if.slave bus
);
  localparam int unsigned            DEPTH    = 1 << FIFO_LOG2;
  localparam logic [FIFO_LOG2:0]     FULL_CNT = (FIFO_LOG2 + 1)'(DEPTH);
  localparam logic [FIFO_LOG2-1:0]   PTR_ONE  = {{(FIFO_LOG2 - 1){1'b0}}, 1'b1};

  logic [7:0] ram [0:(1 << RAM_AW) - 1];

  logic [17:0] addr;
  logic        unused_addr_hi;
  logic        sel_ram, sel_io, io_data, io_snap, io_snap0;
  logic        acc_rd, acc_wr;
  logic [7:0]  rd_byte;
  logic [31:0] cycle_cnt, snap;
  logic [7:0]  data_q;
  logic        done_q;

  logic [7:0]           rx_mem [DEPTH];
  logic [FIFO_LOG2-1:0] rx_wp, rx_rp;
  logic [FIFO_LOG2:0]   rx_cnt;
  logic [7:0]           tx_mem [DEPTH];
  logic [FIFO_LOG2-1:0] tx_wp, tx_rp;
  logic [FIFO_LOG2:0]   tx_cnt;
  logic                 rx_full, rx_empty, tx_full, tx_empty;
  logic                 rx_push, rx_pop, tx_push, tx_pop;
  logic [7:0]           tx_wdata;

  assign addr           = bus.cpu_addr_i[17:0];
  assign unused_addr_hi = ^bus.cpu_addr_i[31:18];

  assign sel_ram  = ~addr[17];
  assign sel_io   = &addr[17:16];
  assign io_data  = sel_io && (addr[15:0] == 16'h0000);
  assign io_snap  = sel_io && (addr[15:2] == 14'h0001);
  assign io_snap0 = io_snap && (addr[1:0] == 2'b00);

  assign rx_full  = (rx_cnt == FULL_CNT);
  assign rx_empty = (rx_cnt == '0);
  assign tx_full  = (tx_cnt == FULL_CNT);
  assign tx_empty = (tx_cnt == '0);

  // A full TX FIFO stalls the CPU, so a write can never overflow it.
  assign acc_rd = ~tx_full & ~bus.cpu_wr_i;
  assign acc_wr = ~tx_full &  bus.cpu_wr_i;

  assign rx_push  = bus.rx_valid_i & ~rx_full;
  assign rx_pop   = acc_rd & io_data & ~rx_empty;
  assign tx_push  = acc_wr & ((io_data & (|bus.cpu_data_i)) | io_snap0);
  assign tx_wdata = io_snap0 ? '0 : bus.cpu_data_i;
  assign tx_pop   = ~tx_empty & bus.tx_ready_i;

  // Byte 0 of the counter port returns the live count that is snapshotted this cycle.
  always_comb begin
    rd_byte = '0;
    if (sel_ram) begin
      rd_byte = ram[addr[RAM_AW-1:0]];
    end else if (io_data) begin
      rd_byte = rx_empty ? '0 : rx_mem[rx_rp];
    end else if (io_snap) begin
      case (addr[1:0])
        2'd0:    rd_byte = cycle_cnt[7:0];
        2'd1:    rd_byte = snap[15:8];
        2'd2:    rd_byte = snap[23:16];
        default: rd_byte = snap[31:24];
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in && acc_wr && sel_ram) ram[addr[RAM_AW-1:0]] <= bus.cpu_data_i;
    if (rx_push) rx_mem[rx_wp] <= bus.rx_data_i;
    if (tx_push) tx_mem[tx_wp] <= tx_wdata;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cycle_cnt <= '0;
      snap      <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      rx_wp     <= '0;
      rx_rp     <= '0;
      rx_cnt    <= '0;
      tx_wp     <= '0;
      tx_rp     <= '0;
      tx_cnt    <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (acc_rd)             data_q <= rd_byte;
      if (acc_rd && io_snap0) snap   <= cycle_cnt;
      if (acc_wr && io_snap0) done_q <= 1'b1;

      if (rx_push) rx_wp <= rx_wp + PTR_ONE;
      if (rx_pop)  rx_rp <= rx_rp + PTR_ONE;
      rx_cnt <= rx_cnt + (FIFO_LOG2 + 1)'(rx_push) - (FIFO_LOG2 + 1)'(rx_pop);

      if (tx_push) tx_wp <= tx_wp + PTR_ONE;
      if (tx_pop)  tx_rp <= tx_rp + PTR_ONE;
      tx_cnt <= tx_cnt + (FIFO_LOG2 + 1)'(tx_push) - (FIFO_LOG2 + 1)'(tx_pop);
    end
  end

  assign bus.cpu_data_o     = data_q;
  assign bus.cpu_rdy_o      = ~tx_full;
  assign bus.rx_ready_o     = ~rx_full;
  assign bus.tx_valid_o     = ~tx_empty;
  assign bus.tx_data_o      = tx_empty ? '0 : tx_mem[tx_rp];
  assign bus.program_done_o = done_q;
endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder: queue/array reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_io_responder;
  logic clk_in = 1'b0;
  logic rst_in;

  mem_io_responder_if bus();

  mem_io_responder #(.RAM_AW(17), .FIFO_LOG2(3)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  int checks   = 0;
  int failures = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: RAM as a sparse map, FIFOs as queues, counter as plain integer.
  logic [7:0]  m_ram [int unsigned];
  logic [7:0]  m_rx [$];
  logic [7:0]  m_tx [$];
  logic [31:0] m_cnt, m_snap;
  logic [7:0]  m_data;
  bit          m_known, m_done;
  logic [17:0] ma;
  bit          m_rdy, m_rx_room;
  int          mk;

  always @(posedge clk_in) begin
    ma = bus.cpu_addr_i[17:0];
    if (rst_in) begin
      m_rx.delete();
      m_tx.delete();
      m_cnt = 0; m_snap = 0; m_data = 0; m_known = 1; m_done = 0;
    end else begin
      m_rdy     = m_tx.size() < 8;
      m_rx_room = m_rx.size() < 8;
      if (m_tx.size() > 0 && bus.tx_ready_i) void'(m_tx.pop_front());
      if (m_rdy && bus.cpu_wr_i) begin
        if (ma < 18'h20000) m_ram[ma[16:0]] = bus.cpu_data_i;
        else if (ma == 18'h30000 && bus.cpu_data_i != 8'h00) m_tx.push_back(bus.cpu_data_i);
        else if (ma == 18'h30004) begin m_done = 1; m_tx.push_back(8'h00); end
      end else if (m_rdy) begin
        m_known = 1;
        if (ma < 18'h20000) begin
          if (m_ram.exists(ma[16:0])) m_data = m_ram[ma[16:0]];
          else m_known = 0;
        end else if (ma == 18'h30000) begin
          if (m_rx.size() > 0) m_data = m_rx.pop_front();
          else m_data = 8'h00;
        end else if (ma == 18'h30004) begin
          m_snap = m_cnt;
          m_data = m_cnt[7:0];
        end else if (ma >= 18'h30005 && ma <= 18'h30007) begin
          mk = int'(ma - 18'h30004);
          m_data = 8'(m_snap >> (8 * mk));
        end else begin
          m_data = 8'h00;
        end
      end
      if (bus.rx_valid_i && m_rx_room) m_rx.push_back(bus.rx_data_i);
      m_cnt = m_cnt + 1;
    end
  end

  always @(negedge clk_in) begin
    if (check_en) begin
      if (m_known) chk("cpu_data_o", 32'(bus.cpu_data_o), 32'(m_data));
      chk("cpu_rdy_o",      32'(bus.cpu_rdy_o),      32'(m_tx.size() < 8));
      chk("rx_ready_o",     32'(bus.rx_ready_o),     32'(m_rx.size() < 8));
      chk("tx_valid_o",     32'(bus.tx_valid_o),     32'(m_tx.size() > 0));
      chk("tx_data_o",      32'(bus.tx_data_o),      32'(m_tx.size() > 0 ? m_tx[0] : 8'h00));
      chk("program_done_o", 32'(bus.program_done_o), 32'(m_done));
    end
  end

  task automatic step();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic idle();
    bus.cpu_addr_i = 32'h0002_0000;
    bus.cpu_data_i = 8'h00;
    bus.cpu_wr_i   = 1'b0;
    bus.rx_valid_i = 1'b0;
    bus.rx_data_i  = 8'h00;
    bus.tx_ready_i = 1'b1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    bus.cpu_addr_i = a; bus.cpu_data_i = d; bus.cpu_wr_i = 1'b1;
    step();
    bus.cpu_wr_i = 1'b0;
    bus.cpu_addr_i = 32'h0002_0000;
  endtask

  task automatic rd(input logic [31:0] a);
    bus.cpu_addr_i = a; bus.cpu_wr_i = 1'b0;
    step();
    bus.cpu_addr_i = 32'h0002_0000;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_data"},  32'(bus.cpu_data_o),     32'h00);
    chk({tag, "_rdy"},   32'(bus.cpu_rdy_o),      32'h1);
    chk({tag, "_txv"},   32'(bus.tx_valid_o),     32'h0);
    chk({tag, "_txd"},   32'(bus.tx_data_o),      32'h00);
    chk({tag, "_rxr"},   32'(bus.rx_ready_o),     32'h1);
    chk({tag, "_done"},  32'(bus.program_done_o), 32'h0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] r;
    logic [17:0] a;
    r = $urandom();
    case ($urandom_range(0, 9))
      0, 1, 2: a = 18'h00010 + 18'($urandom_range(0, 15));
      3:       a = 18'h10000 + 18'($urandom_range(0, 7));
      4:       a = 18'h20000 + 18'($urandom_range(0, 65535));
      5, 6:    a = 18'h30000;
      7:       a = 18'h30004 + 18'($urandom_range(0, 3));
      8:       a = 18'h30000 + 18'($urandom_range(1, 15));
      default: a = 18'($urandom());
    endcase
    r[17:0] = a;
    return r;
  endfunction

  bit tx_hold;

  initial begin
    idle();
    rst_in = 1'b1;
    step();
    step();
    rst_in = 1'b0;
    check_en = 1'b1;
    chk_reset_vals("reset");

    // RAM write then read-after-write, unmapped region reads zero
    wr(32'h0000_0010, 8'hA5);
    rd(32'h0000_0010);
    chk("raw_a5", 32'(bus.cpu_data_o), 32'hA5);
    rd(32'h0002_0000);
    chk("unmapped", 32'(bus.cpu_data_o), 32'h00);

    // RX ordering and empty read
    bus.rx_valid_i = 1'b1; bus.rx_data_i = 8'h41; step();
    bus.rx_data_i = 8'h42; step();
    bus.rx_valid_i = 1'b0;
    rd(32'h0003_0000); chk("rx_first",  32'(bus.cpu_data_o), 32'h41);
    rd(32'h0003_0000); chk("rx_second", 32'(bus.cpu_data_o), 32'h42);
    rd(32'h0003_0000); chk("rx_empty",  32'(bus.cpu_data_o), 32'h00);

    // pop and push together on an empty RX FIFO
    bus.rx_valid_i = 1'b1; bus.rx_data_i = 8'h55;
    rd(32'h0003_0000);
    bus.rx_valid_i = 1'b0;
    chk("rx_popempty", 32'(bus.cpu_data_o), 32'h00);
    rd(32'h0003_0000); chk("rx_pushlanded", 32'(bus.cpu_data_o), 32'h55);

    // fill RX to full
    for (int i = 0; i < 8; i++) begin
      bus.rx_valid_i = 1'b1; bus.rx_data_i = 8'(8'h60 + i); step();
    end
    chk("rx_full", 32'(bus.rx_ready_o), 32'h0);
    bus.rx_data_i = 8'h99; step();
    bus.rx_valid_i = 1'b0;
    chk("rx_full_hold", 32'(bus.rx_ready_o), 32'h0);
    rd(32'h0003_0000); chk("rx_drain0", 32'(bus.cpu_data_o), 32'h60);
    for (int i = 1; i < 8; i++) rd(32'h0003_0000);
    chk("rx_drain7", 32'(bus.cpu_data_o), 32'h67);
    rd(32'h0003_0000); chk("rx_no_overflow", 32'(bus.cpu_data_o), 32'h00);

    // TX zero bytes are dropped
    bus.tx_ready_i = 1'b1;
    wr(32'h0003_0000, 8'h48); chk("tx_48",  32'(bus.tx_data_o),  32'h48);
    wr(32'h0003_0000, 8'h00); chk("tx_zero_dropped", 32'(bus.tx_valid_o), 32'h0);
    wr(32'h0003_0000, 8'h69); chk("tx_69",  32'(bus.tx_data_o),  32'h69);
    step();                   chk("tx_drained", 32'(bus.tx_valid_o), 32'h0);

    // TX full stalls the CPU; a held write during the stall is dropped
    bus.tx_ready_i = 1'b0;
    for (int i = 1; i <= 8; i++) wr(32'h0003_0000, 8'(i));
    chk("tx_full_stall", 32'(bus.cpu_rdy_o), 32'h0);
    bus.cpu_addr_i = 32'h0003_0000; bus.cpu_data_i = 8'hEE; bus.cpu_wr_i = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("tx_stall_held", 32'(bus.cpu_rdy_o), 32'h0);
    chk("tx_head_held",  32'(bus.tx_data_o), 32'h01);
    bus.cpu_wr_i = 1'b0; bus.cpu_addr_i = 32'h0002_0000;
    bus.tx_ready_i = 1'b1;
    step();
    chk("tx_rdy_rise", 32'(bus.cpu_rdy_o), 32'h1);
    chk("tx_next",     32'(bus.tx_data_o), 32'h02);
    for (int i = 0; i < 8; i++) step();
    chk("tx_no_ee", 32'(bus.tx_valid_o), 32'h0);

    // counter snapshot after 300 cycles from reset
    do_reset();
    for (int i = 0; i < 300; i++) step();
    rd(32'h0003_0004); chk("snap_b0", 32'(bus.cpu_data_o), 32'h2C);
    rd(32'h0003_0005); chk("snap_b1", 32'(bus.cpu_data_o), 32'h01);
    rd(32'h0003_0006); chk("snap_b2", 32'(bus.cpu_data_o), 32'h00);
    rd(32'h0003_0007); chk("snap_b3", 32'(bus.cpu_data_o), 32'h00);

    // program stop, then reset in the middle of a TX/RX burst
    wr(32'h0003_0004, 8'h77);
    chk("done_set",  32'(bus.program_done_o), 32'h1);
    chk("done_txv",  32'(bus.tx_valid_o),     32'h1);
    chk("done_txd",  32'(bus.tx_data_o),      32'h00);
    step();
    bus.tx_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.rx_valid_i = 1'b1; bus.rx_data_i = 8'(8'h30 + i);
      wr(32'h0003_0000, 8'(8'h11 + i));
    end
    rd(32'h0003_0000);
    bus.rx_valid_i = 1'b0;
    do_reset();
    chk_reset_vals("midreset");
    bus.tx_ready_i = 1'b1;
    rd(32'h0003_0000); chk("rx_flushed", 32'(bus.cpu_data_o), 32'h00);

    // randomized traffic
    tx_hold = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) tx_hold = ($urandom_range(0, 2) == 0);
      rst_in         = ($urandom_range(0, 399) == 0);
      bus.cpu_addr_i = rand_addr();
      if (tx_hold && $urandom_range(0, 1) == 1) bus.cpu_addr_i[17:0] = 18'h30000;
      bus.cpu_wr_i   = tx_hold ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 2) == 0);
      bus.cpu_data_i = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom());
      bus.rx_valid_i = 1'($urandom_range(0, 1));
      bus.rx_data_i  = 8'($urandom());
      bus.tx_ready_i = tx_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
      step();
    end
    rst_in = 1'b0;
    idle();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
